// File: rtl/meta_pkt_gen.sv
// meta_pkt_gen: AXI-Stream packet generator producing fixed-length packets
// made of a header word followed by PKT_LEN-1 payload words. Channels are
// served round-robin and a sequence number tags every packet.
//
// Ports:
//   clk, resetn        clock (rising edge) and synchronous active-low reset
//   start              one-cycle request to begin generation (IDLE only)
//   stop               one-cycle request to end after the current packet
//   cont               1 = continuous back-to-back packets, 0 = single packet
//   cfg_gap[7:0]       idle cycles inserted between packets in continuous mode
//   axis_out_tdata     stream data (DW bits)
//   axis_out_tvalid    stream valid
//   axis_out_tlast     final word of a packet
//   axis_out_tready    downstream ready
//   busy               state is not IDLE
//   pkt_count[15:0]    completed packet counter, wraps
module meta_pkt_gen #(
    parameter int unsigned DW      = 128,
    parameter int unsigned PKT_LEN = 8,
    parameter int unsigned NCH     = 4,
    parameter logic [15:0] MAGIC   = 16'd1638
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic          stop,
    input  logic          cont,
    input  logic [7:0]    cfg_gap,
    output logic [DW-1:0] axis_out_tdata,
    output logic          axis_out_tvalid,
    output logic          axis_out_tlast,
    input  logic          axis_out_tready,
    output logic          busy,
    output logic [15:0]   pkt_count
);

    localparam logic [15:0] LAST_IDX = 16'(PKT_LEN - 1);
    localparam logic [15:0] CHAN_MAX = 16'(NCH - 1);
    localparam logic [15:0] LEN_FLD  = 16'(PKT_LEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [15:0]   widx, widx_n;
    logic [15:0]   seq, seq_n;
    logic [15:0]   chan, chan_n;
    logic [15:0]   cnt, cnt_n;
    logic          stop_pend, stop_pend_n;
    logic [7:0]    gap_cnt, gap_cnt_n;
    logic [DW-1:0] tdata, tdata_n;
    logic          tvalid, tvalid_n;
    logic          tlast, tlast_n;
    logic          busy_r, busy_n;

    // Word contents for a given index: header at index 0, payload otherwise.
    function automatic logic [DW-1:0] make_word(input logic [15:0] idx,
                                                input logic [15:0] seq_v,
                                                input logic [15:0] chan_v);
        logic [DW-1:0] w;
        w = '0;
        if (idx == 16'd0) begin
            w[DW-1 -: 16] = MAGIC;
            w[47:32]      = seq_v;
            w[31:16]      = chan_v;
            w[15:0]       = LEN_FLD;
        end else begin
            w[31:0] = {seq_v, idx};
        end
        return w;
    endfunction

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= S_IDLE;
            widx      <= '0;
            seq       <= '0;
            chan      <= '0;
            cnt       <= '0;
            stop_pend <= 1'b0;
            gap_cnt   <= '0;
            tdata     <= '0;
            tvalid    <= 1'b0;
            tlast     <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state     <= state_n;
            widx      <= widx_n;
            seq       <= seq_n;
            chan      <= chan_n;
            cnt       <= cnt_n;
            stop_pend <= stop_pend_n;
            gap_cnt   <= gap_cnt_n;
            tdata     <= tdata_n;
            tvalid    <= tvalid_n;
            tlast     <= tlast_n;
            busy_r    <= busy_n;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        logic        hs;
        logic        stop_now;
        logic [15:0] seq_inc;
        logic [15:0] chan_inc;
        logic [15:0] widx_inc;

        state_n     = state;
        widx_n      = widx;
        seq_n       = seq;
        chan_n      = chan;
        cnt_n       = cnt;
        stop_pend_n = stop_pend;
        gap_cnt_n   = gap_cnt;
        tdata_n     = tdata;
        tvalid_n    = tvalid;
        tlast_n     = tlast;

        hs       = tvalid & axis_out_tready;
        stop_now = stop_pend | stop;
        seq_inc  = 16'(seq + 16'd1);
        chan_inc = (chan == CHAN_MAX) ? 16'd0 : 16'(chan + 16'd1);
        widx_inc = 16'(widx + 16'd1);

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n     = S_SEND;
                    widx_n      = '0;
                    stop_pend_n = 1'b0;
                    tvalid_n    = 1'b1;
                    tlast_n     = 1'b0;
                    tdata_n     = make_word(16'd0, seq, chan);
                end
            end

            S_SEND: begin
                if (stop) begin
                    stop_pend_n = 1'b1;
                end
                if (hs) begin
                    if (widx == LAST_IDX) begin
                        seq_n  = seq_inc;
                        chan_n = chan_inc;
                        cnt_n  = 16'(cnt + 16'd1);
                        widx_n = '0;
                        if (cont && !stop_now) begin
                            if (cfg_gap != 8'd0) begin
                                state_n   = S_GAP;
                                gap_cnt_n = cfg_gap;
                                tvalid_n  = 1'b0;
                                tlast_n   = 1'b0;
                                tdata_n   = '0;
                            end else begin
                                // Zero-bubble: next header follows the tlast word directly.
                                tlast_n = 1'b0;
                                tdata_n = make_word(16'd0, seq_inc, chan_inc);
                            end
                        end else begin
                            state_n     = S_IDLE;
                            stop_pend_n = 1'b0;
                            tvalid_n    = 1'b0;
                            tlast_n     = 1'b0;
                            tdata_n     = '0;
                        end
                    end else begin
                        widx_n  = widx_inc;
                        tlast_n = (widx_inc == LAST_IDX);
                        tdata_n = make_word(widx_inc, seq, chan);
                    end
                end
            end

            S_GAP: begin
                if (stop) begin
                    state_n     = S_IDLE;
                    stop_pend_n = 1'b0;
                end else if (gap_cnt <= 8'd1) begin
                    // Last idle cycle: present the next header on the following cycle.
                    state_n  = S_SEND;
                    widx_n   = '0;
                    tvalid_n = 1'b1;
                    tlast_n  = 1'b0;
                    tdata_n  = make_word(16'd0, seq, chan);
                end else begin
                    gap_cnt_n = 8'(gap_cnt - 8'd1);
                end
            end

            default: begin
                state_n  = S_IDLE;
                tvalid_n = 1'b0;
                tlast_n  = 1'b0;
                tdata_n  = '0;
            end
        endcase

        busy_n = (state_n != S_IDLE);
    end

    assign axis_out_tdata  = tdata;
    assign axis_out_tvalid = tvalid;
    assign axis_out_tlast  = tlast;
    assign busy            = busy_r;
    assign pkt_count       = cnt;

endmodule

// File: doc/meta_pkt_gen.md
META_PKT_GEN -- requirements
Module: meta_pkt_gen

Interface
REQ-001 Parameter DW, default 128: AXI-Stream data width in bits; SHALL be a multiple of 8 and >= 64.
REQ-002 Parameter PKT_LEN, default 8: words per packet, including the header; legal range 2..65535.
REQ-003 Parameter NCH, default 4: number of logical channels, served round-robin; legal range 1..65536.
REQ-004 Parameter MAGIC, default 16'd1638: header tag.
REQ-005 clk  in  1  clock; all logic on rising edge.
REQ-006 resetn  in  1  reset, synchronous, active-low.
REQ-007 start  in  1  one-cycle request to begin generation; sampled only in IDLE.
REQ-008 stop  in  1  one-cycle request to end generation after the current packet; sampled in SEND and GAP.
REQ-009 cont  in  1  continuous mode; 1 = back-to-back packets, 0 = single packet per start.
REQ-010 cfg_gap  in  8  idle cycles between packets in continuous mode; sampled when a packet's last word handshakes.
REQ-011 axis_out_tdata  out  DW  stream data.
REQ-012 axis_out_tvalid  out  1  stream valid.
REQ-013 axis_out_tlast  out  1  marks the final word of a packet.
REQ-014 axis_out_tready  in  1  downstream ready.
REQ-015 busy  out  1  high whenever the state is not IDLE.
REQ-016 pkt_count  out  16  number of completed packets; wraps.

Function
REQ-017 The block SHALL implement an FSM with states IDLE, SEND and GAP; all outputs SHALL be registered.
REQ-018 IDLE -> SEND on start=1; the first word SHALL be valid on the cycle after start is sampled.
REQ-019 A handshake SHALL occur on any cycle with tvalid=1 and tready=1; the word index (0..PKT_LEN-1) SHALL advance only on a handshake.
REQ-020 While tvalid=1 and tready=0, tdata, tlast and tvalid SHALL hold stable; tvalid SHALL NOT drop without a handshake.
REQ-021 Word 0 (header) SHALL be: [DW-1:DW-16]=MAGIC, [63:48]=0, [47:32]=seq, [31:16]=chan, [15:0]=PKT_LEN; all other bits 0.
REQ-022 Word i, for i>=1, SHALL be zero-extended {seq[15:0], i[15:0]} in bits [31:0].
REQ-023 tlast SHALL be 1 only on word PKT_LEN-1.
REQ-024 On the last-word handshake, seq and pkt_count SHALL each increment by 1, wrapping 16'hFFFF -> 0.
REQ-025 On the last-word handshake, chan SHALL increment, wrapping NCH-1 -> 0.
REQ-026 On the last-word handshake, if cont=1 and no stop is pending, the FSM SHALL move to GAP when cfg_gap>0, otherwise stay in SEND with the next header presented on the following cycle (zero-bubble).
REQ-027 On the last-word handshake, if cont=0 or a stop is pending, the FSM SHALL go to IDLE.
REQ-028 In GAP, tvalid SHALL be 0 for exactly cfg_gap cycles, after which the FSM SHALL return to SEND.
REQ-029 stop received in SEND SHALL be latched as pending; the current packet SHALL complete in full and the FSM SHALL then go to IDLE.
REQ-030 stop received in GAP SHALL move the FSM to IDLE on the next cycle.
REQ-031 start received while not in IDLE SHALL be ignored.
REQ-032 If start and stop are asserted together in IDLE, start SHALL win; stop is not sampled in IDLE.
REQ-033 seq, chan and pkt_count SHALL persist across IDLE periods; only reset SHALL clear them.

Reset
REQ-034 With resetn=0 at a clock edge, the block SHALL set: state=IDLE, tvalid=0, tlast=0, tdata=0, busy=0, pkt_count=0, seq=0, chan=0, word index=0, stop-pending=0.
REQ-035 Reset mid-packet SHALL abort the packet immediately, with no tlast emitted.
REQ-036 Reset SHALL take priority over all other inputs.

Verification
REQ-037 Single packet: cont=0, tready=1, start pulse -> 8 words on 8 consecutive cycles; header tag 1638, seq=0, chan=0, len=8; tlast on word 7; then busy=0 and pkt_count=1.
REQ-038 Backpressure: tready toggled randomly during a packet -> tdata, tvalid and tlast stable while stalled; word sequence identical to the no-stall case.
REQ-039 Continuous, cfg_gap=0 -> headers back-to-back with no bubble; chan sequence 0,1,2,3,0; seq increments by 1 per packet.
REQ-040 Continuous, cfg_gap=3 -> exactly 3 cycles of tvalid=0 between tlast and the next header.
REQ-041 stop on word 2 -> words 3..7 still sent, then IDLE; a second start mid-packet has no effect.
REQ-042 Reset asserted on word 4 -> the next cycle shows tvalid=0 and pkt_count=0; a subsequent start emits a header with seq=0 and chan=0.
